// File: rtl/divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package divider_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
  import divider_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   rem,
  input  logic                 dvd_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   new_rem,
  output logic                 q_bit
);

  logic        [DIVISOR_W:0]   shifted;
  logic signed [DIVISOR_W+1:0] trial;

  always_comb begin
    shifted = {rem[DIVISOR_W-1:0], dvd_bit};
    trial   = $signed({1'b0, shifted}) - $signed({2'b00, divisor});
    // A set top bit of rem means the shifted value already exceeds any divisor.
    q_bit   = rem[DIVISOR_W] | ~trial[DIVISOR_W+1];
    new_rem = q_bit ? trial[DIVISOR_W:0] : shifted;
  end

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module divider_seq
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] vector1,
  input  logic [DIVISOR_W-1:0]  vector2,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);

  localparam int CW = cnt_width(DIVIDEND_W);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    rem;
  logic [DIVISOR_W:0]    new_rem;
  logic                  q_bit;
  logic                  accept;

  assign accept = start && ((state == IDLE) || (state == DONE));

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem     (rem),
    .dvd_bit (dvd[DIVIDEND_W-1]),
    .divisor (dvs),
    .new_rem (new_rem),
    .q_bit   (q_bit)
  );

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            if (vector2 == '0) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= vector1[DIVISOR_W-1:0];
              div_zero  <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              cnt   <= CW'(DIVIDEND_W - 1);
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (cnt == '0) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {dvd[DIVIDEND_W-2:0], q_bit};
            remainder <= new_rem[DIVISOR_W-1:0];
            div_zero  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operands captured on accept, then shifted one bit per CALC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd <= vector1;
      dvs <= vector2;
      rem <= '0;
    end else if (state == CALC) begin
      dvd <= {dvd[DIVIDEND_W-2:0], q_bit};
      rem <= new_rem;
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq with hand-computed quotients, remainders and latencies.
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] vector1;
  logic [7:0]  vector2;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  divider_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vector1   (vector1),
    .vector2   (vector2),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start in cycle 0; returns in cycle 1 with start low.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    vector1 = a;
    vector2 = b;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // Advance until done is seen, counting cycles from 'from'; bounded.
  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!done && cyc < from + 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pulses;
    rst = 1'b1; start = 1'b0; vector1 = '0; vector2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dz", div_zero, 0);
    rst = 1'b0;
    idle_cycle();

    // 1: 50000 / 7 = 7142 r 6
    start_op(16'hC350, 8'h07);
    check("t1_busy_c1", busy, 1);
    wait_done(1, cyc);
    check("t1_latency", cyc, 17);
    check("t1_busy_at_done", busy, 0);
    check("t1_quot", quotient, 16'h1BE6);
    check("t1_rem", remainder, 8'h06);
    check("t1_dz", div_zero, 0);
    idle_cycle();
    check("t1_done_pulse", done, 0);
    idle_cycle();
    check("t1_quot_held", quotient, 16'h1BE6);
    check("t1_rem_held", remainder, 8'h06);

    // 2: divisor one and divisor larger than dividend
    start_op(16'hFFFF, 8'h01);
    wait_done(1, cyc);
    check("t2a_latency", cyc, 17);
    check("t2a_quot", quotient, 16'hFFFF);
    check("t2a_rem", remainder, 8'h00);
    idle_cycle();
    start_op(16'h0005, 8'hFF);
    wait_done(1, cyc);
    check("t2b_latency", cyc, 17);
    check("t2b_quot", quotient, 16'h0000);
    check("t2b_rem", remainder, 8'h05);
    idle_cycle();

    // 3: divide by zero
    start_op(16'h1234, 8'h00);
    wait_done(1, cyc);
    check("t3_latency", cyc, 1);
    check("t3_quot", quotient, 16'hFFFF);
    check("t3_rem", remainder, 8'h34);
    check("t3_dz", div_zero, 1);
    check("t3_busy", busy, 0);
    idle_cycle();

    // 4: second start during CALC must be ignored
    start_op(16'h0064, 8'h0A);
    repeat (4) begin @(posedge clk); #1; end
    vector1 = 16'h0009; vector2 = 8'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, cyc);
    check("t4_latency", cyc, 17);
    check("t4_quot", quotient, 16'h000A);
    check("t4_rem", remainder, 8'h00);
    check("t4_dz", div_zero, 0);
    idle_cycle();

    // 5: reset in the middle of a calculation
    start_op(16'hC350, 8'h07);
    repeat (7) begin @(posedge clk); #1; end
    check("t5_busy_c8", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_quot", quotient, 0);
    check("t5_rem", remainder, 0);
    check("t5_dz", div_zero, 0);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("t5_no_done", pulses, 0);
    start_op(16'h03E8, 8'h0B);
    wait_done(1, cyc);
    check("t5_new_latency", cyc, 17);
    check("t5_new_quot", quotient, 16'h005A);
    check("t5_new_rem", remainder, 8'h0A);
    idle_cycle();

    // 6: start held high, back-to-back operations
    vector1 = 16'h0100; vector2 = 8'h10; start = 1'b1;
    @(posedge clk); #1;
    wait_done(1, cyc);
    check("t6a_latency", cyc, 17);
    check("t6a_quot", quotient, 16'h0010);
    check("t6a_rem", remainder, 8'h00);
    vector1 = 16'h00FF; vector2 = 8'h10;
    pulses = 0;
    @(posedge clk); #1;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (busy !== 1'b1) pulses++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("t6_gap", cyc, 17);
    check("t6_busy_between", pulses, 0);
    check("t6b_quot", quotient, 16'h000F);
    check("t6b_rem", remainder, 8'h0F);
    idle_cycle();
    check("t6_done_pulse", done, 0);
    check("t6_idle_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
